// File: rtl/dut_arbiter_pkg.sv
// Shared types and constants for the dut_arbiter round-robin sequencer.
package dut_arbiter_pkg;

    localparam int ADDR_W      = 3;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dut_arbiter_rr.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_oh_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             any_o
);

    always_comb begin
        int   idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_i[idx]) begin
                found         = 1'b1;
                gnt_oh_o[idx] = 1'b1;
                gnt_idx_o     = IDX_W'(idx);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/dut_arbiter.sv
// Shares the single dut write/read port among NREQ requesters, one transaction
// at a time, with a ready timeout that turns a stuck access into an error response.
module dut_arbiter
    import dut_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_write,
    input  logic [ADDR_W*NREQ-1:0] req_addr,
    input  logic [NREQ-1:0]        req_wdata,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        resp_valid,
    output logic                   resp_data,
    output logic                   resp_err,
    output logic [ADDR_W-1:0]      write_address,
    output logic                   write_data,
    output logic                   write_en,
    input  logic                   write_rdy,
    output logic [ADDR_W-1:0]      read_address,
    output logic                   read_en,
    input  logic                   read_rdy,
    input  logic                   read_data
);

    localparam int         IDX_W    = $clog2(NREQ);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  gnt_q, gnt_d;
    logic              op_write_q, op_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wdata_q, wdata_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic [NREQ-1:0]   resp_valid_q, resp_valid_d;
    logic              resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              wdat_q, wdat_d;

    logic [NREQ-1:0]   win_oh;
    logic [IDX_W-1:0]  win_idx;
    logic              win_any;
    logic [NREQ-1:0]   gnt_oh;
    logic              fire;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
        .req_i     (req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_oh_o  (win_oh),
        .gnt_idx_o (win_idx),
        .any_o     (win_any)
    );

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt_oh
        assign gnt_oh[gi] = (gnt_q == IDX_W'(gi));
    end

    // Enables follow the ready combinationally so the dut never sees an enable without ready.
    assign write_en  = !RST && (state_q == ISSUE) && op_write_q && write_rdy;
    assign read_en   = !RST && (state_q == ISSUE) && !op_write_q && read_rdy;
    assign fire      = write_en || read_en;
    assign req_ready = (!RST && (state_q == IDLE)) ? win_oh : '0;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        gnt_d        = gnt_q;
        op_write_d   = op_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wait_cnt_d   = wait_cnt_q;
        resp_valid_d = '0;
        resp_data_d  = 1'b0;
        resp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    gnt_d      = win_idx;
                    op_write_d = req_write[win_idx];
                    addr_d     = req_addr[ADDR_W*int'(win_idx) +: ADDR_W];
                    wdata_d    = req_wdata[win_idx];
                    rr_ptr_d   = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
                    wait_cnt_d = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (fire) begin
                    resp_valid_d = gnt_oh;
                    resp_data_d  = op_write_q ? 1'b0 : read_data;
                    state_d      = RESP;
                end else if (wait_cnt_q == TMO_LAST) begin
                    resp_valid_d = gnt_oh;
                    resp_err_d   = 1'b1;
                    state_d      = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Address/data outputs are registered and only carry the latched op while in ISSUE.
        waddr_d = (state_d == ISSUE) ? addr_d  : '0;
        raddr_d = (state_d == ISSUE) ? addr_d  : '0;
        wdat_d  = (state_d == ISSUE) ? wdata_d : 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            gnt_q        <= '0;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 1'b0;
            wait_cnt_q   <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= 1'b0;
            resp_err_q   <= 1'b0;
            waddr_q      <= '0;
            raddr_q      <= '0;
            wdat_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_q        <= gnt_d;
            op_write_q   <= op_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wait_cnt_q   <= wait_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            waddr_q      <= waddr_d;
            raddr_q      <= raddr_d;
            wdat_q       <= wdat_d;
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign resp_err      = resp_err_q;
    assign write_address = waddr_q;
    assign write_data    = wdat_q;
    assign read_address  = raddr_q;

endmodule

// File: doc/dut_arbiter.md
# dut_arbiter

Round-robin arbiter and sequencer that shares the single `dut` write/read method interface among `NREQ` requesters. Each requester submits a write or read transaction. The arbiter grants one transaction at a time and drives the `dut` enable only when the matching ready is high. It returns a one-cycle response carrying the read data, or an error if the `dut` never becomes ready. It sits between the test/host agents and `dut`, alongside `dut_test`.

## Interface

- `NREQ`, default 2 — number of requesters; legal range 2..4.
- `TIMEOUT`, default 16 — cycles the arbiter waits in ISSUE for ready before aborting; range 2..255.
- `CLK` in 1 — single clock, rising edge.
- `RST` in 1 — reset, synchronous, active-high.
- `req_valid` in `NREQ` — per-requester request.
- `req_write` in `NREQ` — 1 = write, 0 = read.
- `req_addr` in `3*NREQ` — packed address; requester i uses bits [3i+2:3i].
- `req_wdata` in `NREQ` — write data bit per requester.
- `req_ready` out `NREQ` — one-hot acceptance pulse.
- `resp_valid` out `NREQ` — one-hot completion pulse.
- `resp_data` out 1 — read data; 0 for writes and errors.
- `resp_err` out 1 — 1 when the transaction timed out.
- `write_address` out 3 — to `dut`.
- `write_data` out 1 — to `dut`.
- `write_en` out 1 — to `dut`.
- `write_rdy` in 1 — from `dut`.
- `read_address` out 3 — to `dut`.
- `read_en` out 1 — to `dut`.
- `read_rdy` in 1 — from `dut`.
- `read_data` in 1 — from `dut`; valid in the same cycle as `read_en & read_rdy`.

## Operation

- **State machine states:** IDLE, ISSUE, RESP.
- **IDLE:**
  - If any `req_valid` bit is high, choose the winner round-robin, starting at index `rr_ptr`.
  - Latch the winner's op, addr and wdata, plus the winner index `gnt`.
  - Pulse `req_ready[gnt]` in this cycle. Set `rr_ptr = (gnt+1) mod NREQ`. Clear `wait_cnt`. Go to ISSUE.
  - If no request is valid, stay in IDLE; `rr_ptr` is unchanged.
- **ISSUE:**
  - Write op: `write_en = write_rdy`. Read op: `read_en = read_rdy`.
  - An enable is never high without its ready in the same cycle. The other enable stays 0.
  - Addresses and `write_data` drive the latched values throughout ISSUE. They are 0 in all other states.
  - Fire (enable high): for a read, capture `read_data`. Set err=0 and go to RESP.
  - No fire: increment `wait_cnt`. When `wait_cnt == TIMEOUT-1` and there is still no fire, set err=1, data=0 and go to RESP.
  - Fire has priority over timeout in the same cycle.
- **RESP:**
  - `resp_valid[gnt]=1` for exactly one cycle, with `resp_data` and `resp_err` driven.
  - Go to IDLE. New requests are not sampled in RESP.
- **Requester contract:** `req_*` must be held stable until `req_ready`. After acceptance the arbiter ignores the requester's inputs.
- **Reset** has priority over every event:
  - All outputs go to 0, state to IDLE, `rr_ptr` to 0, `wait_cnt` to 0.
  - A transaction in progress is dropped with no response.

## Timing

- Acceptance at cycle t. Earliest `dut` enable at t+1. Earliest response at t+2. Earliest next acceptance at t+3.
- Peak throughput: 1 transaction per 3 cycles.
- Timeout response at t+TIMEOUT+1.
- All outputs are registered except:
  - `write_en` and `read_en`: the latched op ANDed with the ready input.
  - `req_ready`: decoded from state and the grant.
- Only one of `req_ready`, `write_en`/`read_en`, `resp_valid` is active in any given cycle.

## Structure

- Package `dut_arbiter_pkg` holds:
  - state enum `arb_state_t` {IDLE, ISSUE, RESP};
  - `ADDR_W = 3`;
  - default `TIMEOUT_DEF = 16`.
- Sub-module `rr_arbiter #(NREQ)`:
  - combinational;
  - inputs: request vector and `rr_ptr`;
  - outputs: one-hot grant, encoded index, any-grant flag.
  - The FSM, latches, `wait_cnt` and pointer stay in `dut_arbiter`.

## Test plan

1. **Reset.** Hold `RST` 3 cycles with all inputs 1. Required: all outputs 0 during reset. First grant afterwards goes to requester 0.
2. **Single write.** Requester 0 writes addr 4, data 1, with `write_rdy=1`. Required: `req_ready[0]` at t, `write_en=1` with addr 4 / data 1 at t+1, `resp_valid[0]=1` with err 0 at t+2.
3. **Round-robin.** Both requesters hold reads of addr 3 continuously, `read_rdy=1`, `read_data=1`. Required: grants alternate 0,1,0,1. Each `resp_data=1`. Acceptances 3 cycles apart.
4. **Ready stall.** Read with `read_rdy=0` for 5 cycles, then 1. Required: `read_en` stays 0 for 5 cycles, then pulses once. Response arrives at t+7 with err 0.
5. **Timeout.** `write_rdy` held 0, `TIMEOUT=16`. Required: `write_en` never asserted. `resp_valid` with `resp_err=1`, `resp_data=0` at t+17.
6. **Reset mid-ISSUE.** Assert `RST` in cycle t+2 of a stalled read. Required: no `resp_valid`. State returns to IDLE. Next grant goes to requester 0.
